// File: rtl/vliw_stall_ctrl.sv
// Hazard-driven stall controller for a multi-slot VLIW pipeline: detects load-use and
// branch-compare hazards in ID and freezes the front end for the required number of cycles.
module vliw_stall_ctrl #(
  parameter int SLOTS        = 2,
  parameter int SRCS         = 3,
  parameter int AW           = 3,
  parameter int BR_LD_STALLS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dec_valid,
  input  logic [SLOTS*SRCS*AW-1:0] dec_src,
  input  logic [SLOTS*SRCS-1:0]    dec_src_vld,
  input  logic [SLOTS-1:0]         dec_is_branch,
  input  logic [SLOTS-1:0]         ex_regwrite,
  input  logic [SLOTS-1:0]         ex_memread,
  input  logic [SLOTS*AW-1:0]      ex_rd,
  input  logic [SLOTS-1:0]         mem_regwrite,
  input  logic [SLOTS-1:0]         mem_memread,
  input  logic [SLOTS*AW-1:0]      mem_rd,
  input  logic                     redirect,
  output logic                     pc_write,
  output logic                     if_id_write,
  output logic                     id_ex_bubble,
  output logic                     stall_busy,
  output logic [15:0]              stall_cycles
);

  localparam int RW = (BR_LD_STALLS < 1) ? 1 : $clog2(BR_LD_STALLS + 1);
  localparam logic [RW-1:0] BR_LD_N = RW'(BR_LD_STALLS);
  localparam logic [RW-1:0] ONE_N   = RW'(1);

  typedef enum logic {IDLE, STALL} state_e;

  state_e        state_q;
  logic [RW-1:0] rem_q;
  logic [15:0]   cyc_q;
  logic [RW-1:0] need_d;
  logic          stall_d;

  function automatic logic [RW-1:0] max_n(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Worst-case stall requirement over every operand x producer-slot pair
  always_comb begin
    logic [AW-1:0] src;
    logic          ex_hit;
    logic          mem_hit;
    need_d  = '0;
    src     = '0;
    ex_hit  = 1'b0;
    mem_hit = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      for (int k = 0; k < SRCS; k++) begin
        src = dec_src[(s*SRCS+k)*AW +: AW];
        if (dec_src_vld[s*SRCS+k] && (src != '0)) begin
          for (int j = 0; j < SLOTS; j++) begin
            ex_hit  = ex_regwrite[j]  && (ex_rd[j*AW +: AW]  == src);
            mem_hit = mem_regwrite[j] && (mem_rd[j*AW +: AW] == src);
            if (ex_hit && ex_memread[j])
              need_d = max_n(need_d, dec_is_branch[s] ? BR_LD_N : ONE_N);
            if (dec_is_branch[s] && ex_hit && !ex_memread[j])
              need_d = max_n(need_d, ONE_N);
            if (dec_is_branch[s] && mem_hit && mem_memread[j])
              need_d = max_n(need_d, ONE_N);
          end
        end
      end
    end
    if (!dec_valid)
      need_d = '0;
  end

  // Redirect and reset both override any hazard in the same cycle
  always_comb begin
    stall_d = 1'b0;
    if (!reset && !redirect)
      stall_d = (state_q == STALL) || (need_d != '0);
  end

  assign pc_write     = ~stall_d;
  assign if_id_write  = ~stall_d;
  assign id_ex_bubble = stall_d;
  assign stall_busy   = (state_q == STALL) && !reset;
  assign stall_cycles = cyc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cyc_q   <= '0;
    end else begin
      if (stall_d && (cyc_q != 16'hFFFF))
        cyc_q <= cyc_q + 16'd1;
      if (redirect) begin
        state_q <= IDLE;
        rem_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (need_d > ONE_N) begin
              state_q <= STALL;
              rem_q   <= need_d - ONE_N;
            end
          end
          STALL: begin
            if (rem_q <= ONE_N) begin
              state_q <= IDLE;
              rem_q   <= '0;
            end else begin
              rem_q <= rem_q - ONE_N;
            end
          end
          default: begin
            state_q <= IDLE;
            rem_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vliw_stall_ctrl.sv
// Scoreboard bench for vliw_stall_ctrl: two instances (BR_LD_STALLS=2 and 4) share stimulus;
// each driven cycle pushes hand-computed expectations that a monitor checks on the falling edge.
module tb_vliw_stall_ctrl;
  localparam int SLOTS = 2;
  localparam int SRCS  = 3;
  localparam int AW    = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     dec_valid;
  logic [SLOTS*SRCS*AW-1:0] dec_src;
  logic [SLOTS*SRCS-1:0]    dec_src_vld;
  logic [SLOTS-1:0]         dec_is_branch;
  logic [SLOTS-1:0]         ex_regwrite, ex_memread, mem_regwrite, mem_memread;
  logic [SLOTS*AW-1:0]      ex_rd, mem_rd;
  logic                     redirect;

  logic        pcw2, ifid2, bub2, busy2;
  logic [15:0] cyc2;
  logic        pcw4, ifid4, bub4, busy4;
  logic [15:0] cyc4;

  always #5 clk = ~clk;

  vliw_stall_ctrl #(.SLOTS(SLOTS), .SRCS(SRCS), .AW(AW), .BR_LD_STALLS(2)) u_dut2 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src(dec_src),
    .dec_src_vld(dec_src_vld), .dec_is_branch(dec_is_branch),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .redirect(redirect), .pc_write(pcw2), .if_id_write(ifid2), .id_ex_bubble(bub2),
    .stall_busy(busy2), .stall_cycles(cyc2));

  vliw_stall_ctrl #(.SLOTS(SLOTS), .SRCS(SRCS), .AW(AW), .BR_LD_STALLS(4)) u_dut4 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src(dec_src),
    .dec_src_vld(dec_src_vld), .dec_is_branch(dec_is_branch),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .redirect(redirect), .pc_write(pcw4), .if_id_write(ifid4), .id_ex_bubble(bub4),
    .stall_busy(busy4), .stall_cycles(cyc4));

  typedef struct {
    string       name;
    logic        pcw2;
    logic        busy2;
    logic [15:0] cyc2;
    logic        pcw4;
    logic        busy4;
    logic [15:0] cyc4;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".pc_write2"},     16'(pcw2),  16'(e.pcw2));
      chk({e.name, ".if_id_write2"},  16'(ifid2), 16'(e.pcw2));
      chk({e.name, ".bubble2"},       16'(bub2),  16'(!e.pcw2));
      chk({e.name, ".stall_busy2"},   16'(busy2), 16'(e.busy2));
      chk({e.name, ".stall_cycles2"}, cyc2,       e.cyc2);
      chk({e.name, ".pc_write4"},     16'(pcw4),  16'(e.pcw4));
      chk({e.name, ".if_id_write4"},  16'(ifid4), 16'(e.pcw4));
      chk({e.name, ".bubble4"},       16'(bub4),  16'(!e.pcw4));
      chk({e.name, ".stall_busy4"},   16'(busy4), 16'(e.busy4));
      chk({e.name, ".stall_cycles4"}, cyc4,       e.cyc4);
    end
  end

  task automatic clr_inputs();
    reset = 1'b0; dec_valid = 1'b1; dec_src = '0; dec_src_vld = '0; dec_is_branch = '0;
    ex_regwrite = '0; ex_memread = '0; ex_rd = '0;
    mem_regwrite = '0; mem_memread = '0; mem_rd = '0; redirect = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr_inputs();
  endtask

  task automatic set_src(input int s, input int k, input int r);
    dec_src[(s*SRCS+k)*AW +: AW] = r[AW-1:0];
    dec_src_vld[s*SRCS+k] = 1'b1;
  endtask

  task automatic set_ex(input int j, input bit ld, input int r);
    ex_regwrite[j] = 1'b1; ex_memread[j] = ld; ex_rd[j*AW +: AW] = r[AW-1:0];
  endtask

  task automatic set_mem(input int j, input bit ld, input int r);
    mem_regwrite[j] = 1'b1; mem_memread[j] = ld; mem_rd[j*AW +: AW] = r[AW-1:0];
  endtask

  task automatic expect_out(input string n, input logic p2, input logic b2, input logic [15:0] c2,
                            input logic p4, input logic b4, input logic [15:0] c4);
    exp_t e;
    e.name = n; e.pcw2 = p2; e.busy2 = b2; e.cyc2 = c2;
    e.pcw4 = p4; e.busy4 = b4; e.cyc4 = c4;
    sb.push_back(e);
  endtask

  task automatic load_use();
    set_src(1, 0, 3); set_ex(0, 1'b1, 3);
  endtask

  task automatic branch_load();
    dec_is_branch[0] = 1'b1; set_src(0, 1, 5); set_ex(1, 1'b1, 5);
  endtask

  initial begin
    clr_inputs();
    reset = 1'b1;
    load_use();
    tick(); reset = 1'b1; load_use();   expect_out("reset_hold",   1, 0, 0, 1, 0, 0);
    tick();                             expect_out("idle",         1, 0, 0, 1, 0, 0);
    tick(); load_use();                 expect_out("load_use",     0, 0, 0, 0, 0, 0);
    tick();                             expect_out("load_use_end", 1, 0, 1, 1, 0, 1);
    tick(); branch_load();              expect_out("br_ld_c0",     0, 0, 1, 0, 0, 1);
    tick();                             expect_out("br_ld_c1",     0, 1, 2, 0, 1, 2);
    tick();                             expect_out("br_ld_c2",     1, 0, 3, 0, 1, 3);
    tick();                             expect_out("br_ld_c3",     1, 0, 3, 0, 1, 4);
    tick();                             expect_out("br_ld_done",   1, 0, 3, 1, 0, 5);
    tick(); branch_load();              expect_out("redir_pre",    0, 0, 3, 0, 0, 5);
    tick(); branch_load(); redirect = 1'b1;
                                        expect_out("redir_stall",  1, 1, 4, 1, 1, 6);
    tick();                             expect_out("redir_after",  1, 0, 4, 1, 0, 6);
    tick(); branch_load(); redirect = 1'b1;
                                        expect_out("redir_idle",   1, 0, 4, 1, 0, 6);
    tick();                             expect_out("redir_idle2",  1, 0, 4, 1, 0, 6);
    tick(); dec_is_branch[0] = 1'b1; set_src(0, 0, 5); set_mem(0, 1'b1, 5); set_ex(1, 1'b0, 5);
                                        expect_out("br_mem_alu",   0, 0, 4, 0, 0, 6);
    tick(); dec_is_branch[0] = 1'b1; set_src(0, 0, 0); set_mem(0, 1'b1, 0); set_ex(1, 1'b0, 0);
                                        expect_out("br_r0",        1, 0, 5, 1, 0, 7);
    tick(); set_src(0, 2, 2); set_ex(0, 1'b0, 2);
                                        expect_out("alu_nobranch", 1, 0, 5, 1, 0, 7);
    tick(); load_use(); dec_valid = 1'b0;
                                        expect_out("dec_invalid",  1, 0, 5, 1, 0, 7);
    tick(); load_use(); dec_src_vld = '0;
                                        expect_out("src_unread",   1, 0, 5, 1, 0, 7);
    tick(); branch_load();              expect_out("rst_stall_c0", 0, 0, 5, 0, 0, 7);
    tick(); reset = 1'b1; load_use();   expect_out("rst_in_stall", 1, 0, 6, 1, 0, 8);
    tick();                             expect_out("rst_released", 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 70000; i++) begin
      tick(); load_use();
    end
    tick(); load_use();                 expect_out("saturated",    0, 0, 16'hFFFF, 0, 0, 16'hFFFF);
    tick(); reset = 1'b1;               expect_out("sat_reset",    1, 0, 16'hFFFF, 1, 0, 16'hFFFF);
    tick();                             expect_out("sat_cleared",  1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain actual=%0d required=0 pending expectations", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
